// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave: AXI4-Lite responder over a word-organised SRAM with fixed response latency.
// Define SRAM_RAND_DELAY_EN to replace LATENCY with an LFSR-driven per-transaction delay.
module axi_lite_sram_slave #(
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam logic [32:0] SPAN = 33'd4 << ADDR_W;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
  logic [31:0] mem [1 << ADDR_W];
  r_state_e rs_q;
  w_state_e ws_q;
  logic [31:0] ar_off, aw_off, wdata_q;
  logic [ADDR_W-1:0] ridx_q, widx_q;
  logic rin_q, win_q;
  logic [3:0] rcnt_q, wcnt_q, wstrb_q, cnt_d;
  assign ar_off = araddr - BASE;
  assign aw_off = awaddr - BASE;
`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge clock)
    lfsr_q <= reset ? 8'hA5 : {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cnt_d = lfsr_q[3:0];
`else
  assign cnt_d = 4'(LATENCY);
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      rs_q    <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
      rcnt_q  <= '0;
      ridx_q  <= '0;
      rin_q   <= 1'b0;
    end else begin
      case (rs_q)
        R_IDLE: if (arvalid) begin
          ridx_q  <= ar_off[ADDR_W+1:2];
          rin_q   <= {1'b0, ar_off} < SPAN;
          rcnt_q  <= cnt_d;
          arready <= 1'b0;
          rs_q    <= R_WAIT;
        end
        R_WAIT: if (rcnt_q == 4'd0) begin
          rdata  <= rin_q ? mem[ridx_q] : 32'h0;
          rresp  <= rin_q ? 2'b00 : 2'b10;
          rvalid <= 1'b1;
          rs_q   <= R_RESP;
        end else rcnt_q <= rcnt_q - 4'd1;
        R_RESP: if (rready) begin
          rvalid  <= 1'b0;
          arready <= 1'b1;
          rs_q    <= R_IDLE;
        end
        default: rs_q <= R_IDLE;
      endcase
    end
  end
  // awready/wready low in W_IDLE doubles as the per-channel "captured" flag
  always_ff @(posedge clock) begin
    if (reset) begin
      ws_q    <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b1;
      bvalid  <= 1'b0;
      bresp   <= '0;
      wcnt_q  <= '0;
      widx_q  <= '0;
      win_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      case (ws_q)
        W_IDLE: begin
          if (awvalid && awready) begin
            widx_q  <= aw_off[ADDR_W+1:2];
            win_q   <= {1'b0, aw_off} < SPAN;
            awready <= 1'b0;
          end
          if (wvalid && wready) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            wready  <= 1'b0;
          end
          if ((!awready || awvalid) && (!wready || wvalid)) begin
            wcnt_q <= cnt_d;
            ws_q   <= W_WAIT;
          end
        end
        W_WAIT: if (wcnt_q == 4'd0) begin
          bresp  <= win_q ? 2'b00 : 2'b10;
          bvalid <= 1'b1;
          ws_q   <= W_RESP;
        end else wcnt_q <= wcnt_q - 4'd1;
        W_RESP: if (bready) begin
          bvalid  <= 1'b0;
          awready <= 1'b1;
          wready  <= 1'b1;
          ws_q    <= W_IDLE;
        end
        default: ws_q <= W_IDLE;
      endcase
    end
  end
  always_ff @(posedge clock)
    if (!reset && ws_q == W_WAIT && wcnt_q == 4'd0 && win_q)
      for (int i = 0; i < 4; i++)
        if (wstrb_q[i]) mem[widx_q][8*i +: 8] <= wdata_q[8*i +: 8];
endmodule
